// File: rtl/repeated_sub_divider.sv
// Unsigned divider by repeated subtraction: start pulse, dividend and divisor
// loaded from a shared bus on consecutive cycles, sticky done.
module repeated_sub_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_DVD = 3'd1,
        LOAD_DVS = 3'd2,
        SUB      = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] divisor, divisor_n;
    logic [WIDTH-1:0] quotient_n, remainder_n;
    logic             dbz_n, busy_n, done_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            divisor     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            divisor     <= divisor_n;
            quotient    <= quotient_n;
            remainder   <= remainder_n;
            div_by_zero <= dbz_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        divisor_n   = divisor;
        quotient_n  = quotient;
        remainder_n = remainder;
        dbz_n       = div_by_zero;

        case (state)
            IDLE: begin
                if (start) state_n = LOAD_DVD;
            end
            LOAD_DVD: begin
                remainder_n = data_in;
                quotient_n  = '0;
                dbz_n       = 1'b0;
                state_n     = LOAD_DVS;
            end
            LOAD_DVS: begin
                divisor_n = data_in;
                if (data_in == '0) begin
                    // Remainder keeps the dividend so software can see what was divided.
                    dbz_n      = 1'b1;
                    quotient_n = '1;
                    state_n    = DONE;
                end else begin
                    state_n = SUB;
                end
            end
            SUB: begin
                if (remainder >= divisor) begin
                    remainder_n = remainder - divisor;
                    quotient_n  = quotient + WIDTH'(1);
                end else begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (start) state_n = LOAD_DVD;
            end
            default: begin
                state_n     = IDLE;
                divisor_n   = '0;
                quotient_n  = '0;
                remainder_n = '0;
                dbz_n       = 1'b0;
            end
        endcase

        // Status flags are registered from the next state so they line up with it.
        busy_n = (state_n == LOAD_DVD) || (state_n == LOAD_DVS) || (state_n == SUB);
        done_n = (state_n == DONE);
    end

endmodule

// File: tb/tb_repeated_sub_divider.sv
// Self-checking bench for repeated_sub_divider: scoreboard of expected
// {div_by_zero, quotient, remainder} plus latency and handshake checks.
module tb_repeated_sub_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] data_in;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    logic [2*W:0] exp_q[$];
    int           pass_cnt = 0;
    int           chk_cnt  = 0;

    repeated_sub_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .data_in     (data_in),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (%0d/%0d checks passed so far)",
                 pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [2*W:0] model(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        if (dvs == 0) return {1'b1, {W{1'b1}}, dvd};
        return {1'b0, W'(dvd / dvs), W'(dvd % dvs)};
    endfunction

    // One division: drives start/operands, optionally pokes start while busy,
    // optionally leaves start held high for back-to-back operation.
    task automatic do_div(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                          input bit inject, input bit hold);
        int          edges;
        int          exp_edges;
        logic [2*W:0] e;
        exp_edges = (dvs == 0) ? 2 : int'(dvd / dvs) + 3;
        exp_q.push_back(model(dvd, dvs));
        start = 1'b1;
        @(posedge clk); #1;                       // E0
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("done_low_in_load", {31'd0, done}, 32'd0);
        if (!hold) start = 1'b0;
        data_in = dvd;
        @(posedge clk); #1;                       // E1
        data_in = dvs;
        @(posedge clk); #1;                       // E2
        data_in = 16'($urandom());
        edges = 2;
        while (!done && edges < exp_edges + 10) begin
            if (inject) start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            edges++;
        end
        if (!hold) start = 1'b0;
        check("latency", edges, exp_edges);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (done) begin
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e[2*W]});
                check("quotient", {16'd0, quotient}, {16'd0, e[2*W-1:W]});
                check("remainder", {16'd0, remainder}, {16'd0, e[W-1:0]});
            end
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_dbz"}, {31'd0, div_by_zero}, 32'd0);
        check({tag, "_q"}, {16'd0, quotient}, 32'd0);
        check({tag, "_r"}, {16'd0, remainder}, 32'd0);
    endtask

    initial begin
        logic [W-1:0] a, b;
        rst = 1'b1; start = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        rst = 1'b0;

        do_div(16'd100, 16'd7, 1'b0, 1'b0);
        do_div(16'd5, 16'd9, 1'b0, 1'b0);
        do_div(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        do_div(16'd42, 16'd0, 1'b0, 1'b0);
        do_div(16'd0, 16'd3, 1'b0, 1'b0);

        // Sticky done while idle in DONE
        repeat (5) @(posedge clk);
        #1;
        check("done_sticky", {31'd0, done}, 32'd1);

        do_div(16'd50, 16'd5, 1'b1, 1'b0);
        do_div(16'd9, 16'd4, 1'b0, 1'b0);

        // Reset in the middle of a long division
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; data_in = 16'd1000;
        @(posedge clk); #1;
        data_in = 16'd3;
        @(posedge clk); #1;
        repeat (20) @(posedge clk);
        #1;
        check("busy_mid_sub", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_cleared("mid_reset");
        do_div(16'd12, 16'd4, 1'b0, 1'b0);

        // Back-to-back with start held high
        do_div(16'd20, 16'd6, 1'b0, 1'b1);
        do_div(16'd8, 16'd8, 1'b0, 1'b1);
        do_div(16'd7, 16'd0, 1'b0, 1'b1);
        start = 1'b0;
        @(posedge clk); #1;
        check("done_after_hold", {31'd0, done}, 32'd1);

        // Random small operands
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom_range(0, 300));
            b = 16'($urandom_range(0, 20));
            do_div(a, b, 1'b0, 1'b0);
        end

        do_div(16'hFFFF, 16'd1, 1'b0, 1'b0);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/repeated_sub_divider.md
# repeated_sub_divider

Unsigned integer divider that computes quotient and remainder by repeated subtraction. It is the inverse of the team's repeated-addition multiplier and uses the same operand-loading and handshake style: a `start` pulse, operands loaded from one shared data bus on consecutive cycles, and a sticky `done`. The FSM and datapath are self-contained in one block, and it sits beside the multiplier behind the same bus master.

## Interface
Parameters:
- `WIDTH`, default 16: width of operands, quotient and remainder.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset, sampled on the `clk` rising edge.
- `start`  in  1  request a new division; sampled only in IDLE and DONE.
- `data_in`  in  WIDTH  shared operand bus; dividend on the first load cycle, divisor on the second.
- `busy`  out  1  high from operand load through the end of subtraction.
- `done`  out  1  result valid; sticky until the next accepted `start` or `rst`.
- `div_by_zero`  out  1  divisor was 0; valid while `done` is high.
- `quotient`  out  WIDTH  quotient register.
- `remainder`  out  WIDTH  remainder register; holds the working value during SUB.

## Operation
- All outputs are registered. On reset: state IDLE, and `busy`, `done`, `div_by_zero`, `quotient`, `remainder` and the internal divisor register are all 0.
- IDLE: if `start`=1, go to LOAD_DVD; otherwise stay.
- LOAD_DVD: `remainder` <= `data_in` (the dividend), `quotient` <= 0, `div_by_zero` <= 0, `done` <= 0. Go to LOAD_DVS.
- LOAD_DVS: divisor register <= `data_in`.
  - If `data_in`==0: `div_by_zero` <= 1, `quotient` <= all ones, `remainder` keeps the dividend, go to DONE.
  - Otherwise go to SUB.
- SUB, evaluated once per cycle:
  - If `remainder` >= divisor: `remainder` <= `remainder` - divisor, `quotient` <= `quotient` + 1, stay in SUB.
  - Otherwise go to DONE.
- DONE: `done`=1; `quotient` and `remainder` are held.
  - If `start`=1, go to LOAD_DVD. `done` drops on that same edge transition, i.e. it is 0 in the LOAD_DVD cycle.
  - Otherwise stay in DONE indefinitely.
- `busy`=1 in LOAD_DVD, LOAD_DVS and SUB; 0 in IDLE and DONE.
- `start` is ignored in LOAD_DVD, LOAD_DVS and SUB. A running division cannot be restarted except by `rst`.
- Arithmetic is unsigned, WIDTH bits. The comparison is a full WIDTH-bit unsigned >=. The subtraction never underflows because it is guarded by the comparison.
- `quotient` cannot overflow: for divisor >= 1, quotient <= dividend <= 2^WIDTH-1.
- State encoding: IDLE=0, LOAD_DVD=1, LOAD_DVS=2, SUB=3, DONE=4. Any other code returns to IDLE on the next edge with all outputs cleared.

## Timing
- Edge E0 samples `start`=1 (in IDLE or DONE). Edge E1 captures the dividend from `data_in`. Edge E2 captures the divisor from `data_in`.
- Divisor nonzero, quotient Q: SUB takes Q+1 edges (E3..E(Q+3)). `done` is first high after edge E(Q+3), so start-to-done is Q+3 edges.
- Divisor zero: `done` and `div_by_zero` are high after E2.
- The bus master must hold the dividend on `data_in` for the cycle ending at E1 and the divisor for the cycle ending at E2. `data_in` is don't-care at all other times.
- `rst` high at any edge, including mid-SUB: the next state is IDLE, all outputs 0, and the in-flight result is discarded. `rst` takes priority over `start`.
- `start` held high continuously: one division per pass. After DONE it immediately restarts, and `done` is high for exactly one cycle per result.
- Dividend < divisor: SUB runs 1 edge, giving `quotient`=0 and `remainder`=dividend; `done` is high after E3.
- Dividend 0, divisor nonzero: `quotient`=0, `remainder`=0, `done` after E3.

## Test plan
- Basic: dividend 100, divisor 7 → `quotient`=14, `remainder`=2, `done` first high after E17, `busy` 0 in the same cycle, `div_by_zero`=0.
- Boundaries:
  - dividend 5, divisor 9 → q=0, r=5, done after E3.
  - dividend 0xFFFF, divisor 1 → q=0xFFFF, r=0, done after E65538.
  - dividend 0xFFFF, divisor 0xFFFF → q=1, r=0.
- Divide by zero: dividend 42, divisor 0 → `div_by_zero`=1, `quotient`=0xFFFF, `remainder`=42, `done` after E2.
- Start during busy: start pulses injected during SUB of 50/5 → no effect, result q=10, r=0. A subsequent start in DONE with 9/4 → `done` drops at the LOAD_DVD cycle, then q=2, r=1.
- Reset mid-operation: assert `rst` for one edge during SUB of 1000/3 → IDLE with all outputs 0. A next division of 12/4 → q=3, r=0 with normal latency.
- Back-to-back: `start` held high over three divisions (20/6, 8/8, 7/0) → results (3,2), (1,0), (0xFFFF,7, dbz=1) in order, with `done` a one-cycle pulse for each.
